// File: rtl/i2s_tx_if.sv
// I2S transmitter master: AXI-Stream 64-bit stereo-lane words out on two SD lanes, MSB-first, with SCK/WS generation.
// Optional saturating underrun counter and its underrun_cnt port: define I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_if #(
   parameter int unsigned CLKDIV_VAL = 20
) (
   input  logic        s_axis_aclk,
   input  logic        s_axis_arstn,
   input  logic [63:0] s_axis_tdata,
   input  logic        s_axis_tuser,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic        WS,
   output logic        SCK,
   output logic [1:0]  SD,
   output logic        underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0] underrun_cnt
`endif
);

   localparam int unsigned DIV_W  = (CLKDIV_VAL < 2) ? 1 : $clog2(CLKDIV_VAL + 1);
   localparam int unsigned DATA_W = 64;
   localparam int unsigned SLOT_W = 32;
   localparam int unsigned BIT_W  = 5;

   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLKDIV_VAL);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKDIV_VAL / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);

   logic [DIV_W-1:0]  r_div;
   logic              r_sck;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic              r_ws;
   logic [SLOT_W-1:0] r_sh_h;
   logic [SLOT_W-1:0] r_sh_l;
   logic [DATA_W-1:0] r_hold_data;
   logic              r_hold_user;
   logic              r_hold_valid;
   logic              r_tready;
   logic              r_underrun;

   logic w_clk_en;
   logic w_boundary;
   logic w_load_ok;
   logic w_accept;
   logic w_hold_valid_nxt;

   // The held word is only consumed when it targets the slot that is about to start.
   always_comb begin
      w_clk_en         = (r_div == DIV_MAX);
      w_boundary       = w_clk_en && (r_bit_cnt == BIT_LAST);
      w_load_ok        = r_hold_valid && (r_hold_user == ~r_ws);
      w_accept         = s_axis_tvalid && r_tready;
      w_hold_valid_nxt = r_hold_valid;
      if (w_boundary && w_load_ok) w_hold_valid_nxt = 1'b0;
      if (w_accept)                w_hold_valid_nxt = 1'b1;
   end

   // Bit clock: SCK falls at the divider wrap (SD launch) and rises mid-period.
   always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
      if (!s_axis_arstn) begin
         r_div     <= '0;
         r_sck     <= 1'b0;
         r_bit_cnt <= '0;
         r_ws      <= 1'b0;
      end else begin
         r_div <= w_clk_en ? '0 : r_div + DIV_W'(1);
         if (w_clk_en)              r_sck <= 1'b0;
         else if (r_div == DIV_HALF) r_sck <= 1'b1;
         if (w_clk_en)   r_bit_cnt <= r_bit_cnt + BIT_W'(1);
         if (w_boundary) r_ws      <= ~r_ws;
      end
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
      if (!s_axis_arstn) begin
         r_sh_h       <= '0;
         r_sh_l       <= '0;
         r_hold_data  <= '0;
         r_hold_user  <= 1'b0;
         r_hold_valid <= 1'b0;
         r_tready     <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_underrun <= w_boundary && !w_load_ok;
         if (w_boundary) begin
            r_sh_h <= w_load_ok ? r_hold_data[63:32] : '0;
            r_sh_l <= w_load_ok ? r_hold_data[31:0]  : '0;
         end else if (w_clk_en) begin
            r_sh_h <= {r_sh_h[SLOT_W-2:0], 1'b0};
            r_sh_l <= {r_sh_l[SLOT_W-2:0], 1'b0};
         end
         if (w_accept) begin
            r_hold_data <= s_axis_tdata;
            r_hold_user <= s_axis_tuser;
         end
         r_hold_valid <= w_hold_valid_nxt;
         r_tready     <= !w_hold_valid_nxt;
      end
   end

`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] r_ur_cnt;

   always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
      if (!s_axis_arstn)                    r_ur_cnt <= '0;
      else if (r_underrun && (r_ur_cnt != '1)) r_ur_cnt <= r_ur_cnt + 16'd1;
   end

   assign underrun_cnt = r_ur_cnt;
`endif

   assign s_axis_tready = r_tready;
   assign WS            = r_ws;
   assign SCK           = r_sck;
   assign SD            = {r_sh_h[SLOT_W-1], r_sh_l[SLOT_W-1]};
   assign underrun      = r_underrun;

endmodule

// File: tb/tb_i2s_tx_if.sv
// Directed bench for i2s_tx_if with CLKDIV_VAL=4: vector table of {drive, expected outputs} plus reset sequences.
module tb_i2s_tx_if;

   localparam int unsigned DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [63:0] tdata = '0;
   logic        tuser = 1'b0;
   logic        tvalid = 1'b0;
   logic        tready;
   logic        ws;
   logic        sck;
   logic [1:0]  sd;
   logic        ur;
`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] ur_cnt;
`endif

   int unsigned cyc;
   int          n_tests = 0;
   int          n_fail  = 0;

   i2s_tx_if #(.CLKDIV_VAL(DIV)) dut (
      .s_axis_aclk   (clk),
      .s_axis_arstn  (rst_n),
      .s_axis_tdata  (tdata),
      .s_axis_tuser  (tuser),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .WS            (ws),
      .SCK           (sck),
      .SD            (sd),
      .underrun      (ur)
`ifdef I2S_TX_UNDERRUN_CNT_EN
      ,
      .underrun_cnt  (ur_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Posedges since reset release; cyc == P means P rising edges have occurred.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   typedef struct {
      int unsigned p;
      logic        vld;
      logic [63:0] data;
      logic        user;
      logic [5:0]  exp;   // {WS, SCK, SD[1:0], tready, underrun}
   } vec_t;

   vec_t tbl[$];

   localparam logic [63:0] W_A = 64'hA5A5_0000_8000_0001;
   localparam logic [63:0] W_B = 64'h0000_0001_FFFF_FFFE;
   localparam logic [63:0] W_C = 64'hC000_0000_0000_0001;
   localparam logic [63:0] W_D = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] W_E = 64'h1234_5678_9ABC_DEF0;

   function automatic vec_t mk(int unsigned p, logic vld, logic [63:0] d, logic u,
                               logic w, logic s, logic [1:0] l, logic r, logic x);
      vec_t v;
      v.p = p; v.vld = vld; v.data = d; v.user = u;
      v.exp = {w, s, l, r, x};
      return v;
   endfunction

   function automatic logic [5:0] outs();
      return {ws, sck, sd, tready, ur};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cyc=%0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int unsigned p);
      while (cyc < p) begin
         @(posedge clk);
         #1;
      end
      if (cyc != p) begin
         n_fail++;
         $display("FAIL sched: at cyc %0d expected cyc %0d", cyc, p);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      tbl.push_back(mk(  1, 1, W_A, 1, 0,0,2'b00,1,0));
      tbl.push_back(mk(  2, 0, '0,  0, 0,0,2'b00,0,0));
      tbl.push_back(mk(  3, 0, '0,  0, 0,1,2'b00,0,0));
      tbl.push_back(mk(  5, 0, '0,  0, 0,0,2'b00,0,0));
      tbl.push_back(mk(159, 0, '0,  0, 0,1,2'b00,0,0));
      tbl.push_back(mk(160, 1, W_B, 0, 1,0,2'b11,1,0));
      tbl.push_back(mk(161, 0, '0,  0, 1,0,2'b11,0,0));
      tbl.push_back(mk(164, 0, '0,  0, 1,1,2'b11,0,0));
      tbl.push_back(mk(165, 0, '0,  0, 1,0,2'b00,0,0));
      tbl.push_back(mk(170, 0, '0,  0, 1,0,2'b10,0,0));
      tbl.push_back(mk(175, 0, '0,  0, 1,0,2'b00,0,0));
      tbl.push_back(mk(185, 0, '0,  0, 1,0,2'b10,0,0));
      tbl.push_back(mk(315, 0, '0,  0, 1,0,2'b01,0,0));
      tbl.push_back(mk(319, 0, '0,  0, 1,1,2'b01,0,0));
      tbl.push_back(mk(320, 1, W_C, 0, 0,0,2'b01,1,0));
      tbl.push_back(mk(321, 0, '0,  0, 0,0,2'b01,0,0));
      tbl.push_back(mk(475, 0, '0,  0, 0,0,2'b10,0,0));
      tbl.push_back(mk(479, 0, '0,  0, 0,1,2'b10,0,0));
      tbl.push_back(mk(480, 0, '0,  0, 1,0,2'b00,0,1));
      tbl.push_back(mk(481, 0, '0,  0, 1,0,2'b00,0,0));
      tbl.push_back(mk(639, 0, '0,  0, 1,1,2'b00,0,0));
      tbl.push_back(mk(640, 1, W_D, 1, 0,0,2'b10,1,0));
      tbl.push_back(mk(641, 0, '0,  0, 0,0,2'b10,0,0));
      tbl.push_back(mk(645, 0, '0,  0, 0,0,2'b10,0,0));
      tbl.push_back(mk(650, 0, '0,  0, 0,0,2'b00,0,0));
      tbl.push_back(mk(795, 0, '0,  0, 0,0,2'b01,0,0));
      tbl.push_back(mk(799, 0, '0,  0, 0,1,2'b01,0,0));
      tbl.push_back(mk(800, 1, W_E, 0, 1,0,2'b11,1,0));
      tbl.push_back(mk(801, 0, '0,  0, 1,0,2'b11,0,0));
      tbl.push_back(mk(883, 0, '0,  0, 1,1,2'b11,0,0));

      // Reset held: everything at reset values, tready low.
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", 16'(outs()), 16'(6'b0));
`ifdef I2S_TX_UNDERRUN_CNT_EN
      chk("reset_cnt", ur_cnt, 16'd0);
`endif
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         wait_cyc(tbl[i].p);
         chk($sformatf("vec[%0d]@%0d", i, tbl[i].p), 16'(outs()), 16'(tbl[i].exp));
         tvalid = tbl[i].vld;
         tdata  = tbl[i].data;
         tuser  = tbl[i].user;
      end
`ifdef I2S_TX_UNDERRUN_CNT_EN
      chk("cnt_one", ur_cnt, 16'd1);
`endif

      // Mid-slot reset with a word held: immediate return to reset values, held word dropped.
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_outs", 16'(outs()), 16'(6'b0));
`ifdef I2S_TX_UNDERRUN_CNT_EN
      chk("midreset_cnt", ur_cnt, 16'd0);
`endif
      @(negedge clk) rst_n = 1'b1;
      wait_cyc(1);
      chk("rel_ready", 16'(outs()), 16'(6'b0_0_00_1_0));
      wait_cyc(159);
      chk("rel_last_slot0", 16'(outs()), 16'(6'b0_1_00_1_0));
      wait_cyc(160);
      chk("rel_dropped_word", 16'(outs()), 16'(6'b1_0_00_1_1));
      wait_cyc(161);
      chk("rel_pulse_end", 16'(outs()), 16'(6'b1_0_00_1_0));
      wait_cyc(320);
      chk("rel_starved", 16'(outs()), 16'(6'b0_0_00_1_1));
      wait_cyc(321);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      chk("cnt_two", ur_cnt, 16'd2);
`endif
      chk("rel_pulse_end2", 16'(outs()), 16'(6'b0_0_00_1_0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2s_tx_if.md
# i2s_tx_if

I2S transmitter master for the sonar audio path: accepts 64-bit stereo-lane words on an AXI-Stream slave and serialises them MSB-first onto two SD lanes, generating SCK and WS itself. It is the output counterpart of the I2S capture interface. Bit timing matches capture exactly, so a loopback of SD into the receiver returns the same words. It sits between a DMA/DSP AXI-Stream source and the external DAC/transducer drivers.

## Interface
- CLKDIV_VAL, 20: SCK period is CLKDIV_VAL+1 clock cycles; must be ≥ 3.
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_arstn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  64  [63:32] → SD[1] slot word, [31:0] → SD[0] slot word.
- s_axis_tuser  in  1  target WS level of the slot this word is for.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  high when the one-entry holding register is empty.
- WS  out  1  word select; toggles every 32 SCK periods.
- SCK  out  1  serial bit clock.
- SD  out  2  serial data lanes.
- underrun  out  1  one-cycle pulse per slot sent as zeros.
- underrun_cnt  out  16  saturating underrun count (only with I2S_TX_UNDERRUN_CNT_EN).

## Operation
- Divider: clkdiv_cnt counts 0..CLKDIV_VAL, wraps to 0; clk_en = (clkdiv_cnt == CLKDIV_VAL).
- SCK register: cleared when clkdiv_cnt == CLKDIV_VAL, set when clkdiv_cnt == CLKDIV_VAL/2 (integer division). SD changes on SCK falling edge; the receiver samples on the rising edge.
- bit_cnt: 5-bit, increments on clk_en, wraps 31→0 naturally.
- Slot boundary = clk_en && bit_cnt == 31. At each boundary: WS toggles; the shift registers load for the new slot (new WS value = ~WS).
- Holding register: 64-bit data + tuser + hold_valid. Handshake: transfer when tvalid && tready; tready = !hold_valid (no combinational path from tvalid).
- Load rule at boundary: if hold_valid && hold_tuser == ~WS → sh_h ← data[63:32], sh_l ← data[31:0], hold_valid cleared. Otherwise sh_h/sh_l ← 0 and underrun pulses next cycle; a held word with wrong tuser stays held and goes out one slot later (self-realignment).
- Non-boundary clk_en: sh_h, sh_l shift left by one, zero fill.
- SD[1] = sh_h[31], SD[0] = sh_l[31], direct register outputs.
- Boundary and a new handshake on the same cycle: load uses hold contents before the handshake; since tready is low when hold is full, no conflict arises. If hold is empty at the boundary, the word accepted that cycle is for the next slot.

## Timing
- Reset values: WS=0, SCK=0, SD=2'b00, s_axis_tready=0 during reset then 1, underrun=0, underrun_cnt=0; clkdiv_cnt, bit_cnt, shift regs, hold_valid all 0.
- Slot = 32·(CLKDIV_VAL+1) cycles; frame = two slots.
- First boundary after reset occurs at cycle 32·(CLKDIV_VAL+1)−1 after reset release; the slot before it (WS=0) always transmits zeros without an underrun pulse.
- Latency: MSB of a loaded word appears on SD one cycle after the boundary clk_en, coincident with the WS toggle.
- Reset mid-slot: all state returns to reset values asynchronously; a held word is discarded.

## Configuration
- I2S_TX_UNDERRUN_CNT_EN defined: underrun_cnt port present; increments on each underrun pulse, saturates at 16'hFFFF, cleared only by reset.
- Not defined: port and counter absent; underrun pulse unchanged.

## Test plan
- CLKDIV_VAL=4, reset release, no traffic → WS toggles every 160 cycles; SD stays 0; underrun pulses at every boundary except during the first (WS=0) slot.
- Word 64'hA5A5_0000_8000_0001 with tuser=1, offered before the first boundary → SD[1] serialises 0xA5A50000 and SD[0] serialises 0x80000001 MSB-first in the WS=1 slot; tready is low from acceptance until the boundary.
- Word with tuser=0 held at a boundary where WS becomes 1 → zeros sent with one underrun pulse; word sent in the following WS=0 slot.
- Back-to-back stream alternating tuser 1,0,1,0 with tvalid held high → no underrun after the first slot; loopback into the capture block reproduces identical 64-bit words.
- Assert arstn low midway through a slot with hold full → all outputs at reset values immediately; tready returns to 1 after release.
- Macro on, 70000 starved slots (forced) → underrun_cnt saturates at 0xFFFF.
